// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial fusion integrator.
// The calibration length, the accel scale factor and the integrator geometry live here.
package inert_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAL  = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int RATE_W        = 16;
    localparam int CAL_LOG2_FAST = 8;
    localparam int CAL_LOG2_FULL = 11;
    localparam int ACC_SCALE     = 327;
    localparam int INT_W         = 27;
    localparam int OUT_LSB       = 11;

    function automatic int cal_log2(input bit fast_sim);
        return fast_sim ? CAL_LOG2_FAST : CAL_LOG2_FULL;
    endfunction

    // Accel-derived angle: (a * 327) >>> 8. Bits [23:8] of the product are the 16-bit result.
    function automatic logic [15:0] acc_angle(input logic [15:0] a);
        logic signed [31:0] prod;
        prod = 32'($signed(a)) * 32'sd327;
        return prod[23:8];
    endfunction

endpackage

// File: rtl/inert_axis_acc.sv
// One axis: it accumulates the calibration sum, holds the rate offset, and integrates the
// offset-corrected rate with an optional +/-FUSION pull toward the accel-derived angle.
module inert_axis_acc
    import inert_pkg::*;
#(
    parameter int CAL_LOG2 = 8,
    parameter int FUSION   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        cal_en,
    input  logic        cal_last,
    input  logic        run_en,
    input  logic [15:0] rate,
    input  logic        fus_en,
    input  logic [15:0] acc_ang,
    output logic [15:0] ang
);
    localparam int SUM_W = RATE_W + CAL_LOG2;

    logic signed [SUM_W-1:0] sum_q, sum_d, sum_shift;
    logic signed [15:0]      off_q, off_d;
    logic signed [INT_W-1:0] int_q, int_d, fus;
    logic signed [16:0]      diff;
    logic signed [15:0]      ang_q;

    always_comb begin
        sum_d     = sum_q + SUM_W'($signed(rate));
        sum_shift = sum_d >>> CAL_LOG2;
        off_d     = sum_shift[15:0];
        diff      = {rate[15], rate} - {off_q[15], off_q};
        fus       = '0;
        if (fus_en) begin
            // Compare against the angle currently presented, not the raw integrator
            fus = ($signed(acc_ang) > ang_q) ? INT_W'(FUSION) : -INT_W'(FUSION);
        end
        int_d = int_q + INT_W'(diff) + fus;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            off_q <= '0;
            int_q <= '0;
            ang_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
            int_q <= '0;
            ang_q <= '0;
        end else begin
            if (cal_en) begin
                sum_q <= sum_d;
                if (cal_last) off_q <= off_d;
            end
            if (run_en) begin
                int_q <= int_d;
                ang_q <= int_d[INT_W-1:OUT_LSB];
            end
        end
    end

    assign ang = ang_q;

endmodule

// File: rtl/inert_fusion_integ.sv
// Gyro calibration and integration with accel fusion on pitch and roll.
// Handshake: vld is a one-cycle strobe with no backpressure; strt_cal overrides a coincident vld.
module inert_fusion_integ
    import inert_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1,
    parameter int FUSION   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cal,
    input  logic        vld,
    input  logic [15:0] ptch_rt,
    input  logic [15:0] roll_rt,
    input  logic [15:0] yaw_rt,
    input  logic [15:0] ax,
    input  logic [15:0] ay,
    output logic        cal_done,
    output logic [15:0] ptch,
    output logic [15:0] roll,
    output logic [15:0] yaw,
    output logic [1:0]  state_dbg
);
    localparam int CAL_LOG2 = cal_log2(FAST_SIM);

    state_t              state_q;
    logic [CAL_LOG2-1:0] cnt_q;
    logic                cal_done_q;
    logic                cal_last, cal_en, run_en;
    logic [15:0]         acc_ptch, acc_roll;

    assign cal_last = &cnt_q;
    assign cal_en   = (state_q == CAL) && vld && !strt_cal;
    assign run_en   = (state_q == RUN) && vld && !strt_cal;
    assign acc_ptch = acc_angle(ay);
    assign acc_roll = acc_angle(ax);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cal_done_q <= 1'b0;
        end else if (strt_cal) begin
            state_q    <= CAL;
            cnt_q      <= '0;
            cal_done_q <= 1'b0;
        end else begin
            case (state_q)
                CAL: if (vld) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cal_last) begin
                        state_q    <= RUN;
                        cal_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    inert_axis_acc #(.CAL_LOG2(CAL_LOG2), .FUSION(FUSION)) u_ptch (
        .clk(clk), .rst(rst), .clr(strt_cal), .cal_en(cal_en), .cal_last(cal_last),
        .run_en(run_en), .rate(ptch_rt), .fus_en(1'b1), .acc_ang(acc_ptch), .ang(ptch)
    );

    inert_axis_acc #(.CAL_LOG2(CAL_LOG2), .FUSION(FUSION)) u_roll (
        .clk(clk), .rst(rst), .clr(strt_cal), .cal_en(cal_en), .cal_last(cal_last),
        .run_en(run_en), .rate(roll_rt), .fus_en(1'b1), .acc_ang(acc_roll), .ang(roll)
    );

    inert_axis_acc #(.CAL_LOG2(CAL_LOG2), .FUSION(FUSION)) u_yaw (
        .clk(clk), .rst(rst), .clr(strt_cal), .cal_en(cal_en), .cal_last(cal_last),
        .run_en(run_en), .rate(yaw_rt), .fus_en(1'b0), .acc_ang(16'd0), .ang(yaw)
    );

    assign cal_done  = cal_done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_inert_fusion_integ.sv
// Directed and randomized bench for inert_fusion_integ with an arithmetic reference model.
module tb_inert_fusion_integ;
  localparam int N   = 256;
  localparam int FUS = 1024;

  logic        clk = 1'b0;
  logic        rst, strt_cal, vld;
  logic [15:0] ptch_rt, roll_rt, yaw_rt, ax, ay;
  logic        cal_done;
  logic [15:0] ptch, roll, yaw;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  // reference model state
  int     m_mode;  // 0 idle, 1 calibrating, 2 running
  bit     m_done;
  longint m_cnt;
  longint m_sum[3];
  longint m_off[3];
  longint m_int[3];
  longint m_out[3];

  inert_fusion_integ #(.FAST_SIM(1'b1), .FUSION(FUS)) dut (
    .clk(clk), .rst(rst), .strt_cal(strt_cal), .vld(vld),
    .ptch_rt(ptch_rt), .roll_rt(roll_rt), .yaw_rt(yaw_rt), .ax(ax), .ay(ay),
    .cal_done(cal_done), .ptch(ptch), .roll(roll), .yaw(yaw), .state_dbg(state_dbg)
  );

  always #10 clk = ~clk;

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint wrap(input longint a, input longint m);
    longint t;
    t = a % m;
    if (t < 0) t = t + m;
    if (t >= m / 2) t = t - m;
    return t;
  endfunction

  task automatic model_clear();
    m_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      m_sum[i] = 0;
      m_int[i] = 0;
      m_out[i] = 0;
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit v,
                            input longint rt0, input longint rt1, input longint rt2,
                            input longint axv, input longint ayv);
    longint rt[3];
    longint fus[3];
    longint acc_p, acc_r;
    rt[0] = rt0; rt[1] = rt1; rt[2] = rt2;
    if (r) begin
      m_mode = 0;
      m_done = 0;
      model_clear();
      for (int i = 0; i < 3; i++) m_off[i] = 0;
    end else if (s) begin
      m_mode = 1;
      m_done = 0;
      model_clear();
    end else if (v && m_mode == 1) begin
      for (int i = 0; i < 3; i++) m_sum[i] += rt[i];
      m_cnt++;
      if (m_cnt == N) begin
        for (int i = 0; i < 3; i++) m_off[i] = fdiv(m_sum[i], N);
        m_mode = 2;
        m_done = 1;
      end
    end else if (v && m_mode == 2) begin
      acc_p = wrap(fdiv(ayv * 327, 256), 65536);
      acc_r = wrap(fdiv(axv * 327, 256), 65536);
      fus[0] = (acc_p > m_out[0]) ? FUS : -FUS;
      fus[1] = (acc_r > m_out[1]) ? FUS : -FUS;
      fus[2] = 0;
      for (int i = 0; i < 3; i++) begin
        m_int[i] = wrap(m_int[i] + (rt[i] - m_off[i]) + fus[i], 134217728);
        m_out[i] = fdiv(m_int[i], 2048);
      end
    end
    exp_q.push_back(16'(m_out[0]));
    exp_q.push_back(16'(m_out[1]));
    exp_q.push_back(16'(m_out[2]));
    exp_q.push_back(16'(m_done));
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp_v));
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_ptch"}, ptch, exp_q.pop_front());
    check({tag, "_roll"}, roll, exp_q.pop_front());
    check({tag, "_yaw"}, yaw, exp_q.pop_front());
    check({tag, "_cal_done"}, {15'd0, cal_done}, exp_q.pop_front());
  endtask

  task automatic cyc(input bit r, input bit s, input bit v,
                     input logic [15:0] p, input logic [15:0] ro, input logic [15:0] y,
                     input logic [15:0] a_x, input logic [15:0] a_y, input string tag);
    @(negedge clk);
    rst = r; strt_cal = s; vld = v;
    ptch_rt = p; roll_rt = ro; yaw_rt = y; ax = a_x; ay = a_y;
    @(posedge clk);
    model_step(r, s, v, longint'($signed(p)), longint'($signed(ro)), longint'($signed(y)),
               longint'($signed(a_x)), longint'($signed(a_y)));
    #1;
    check_outputs(tag);
    @(negedge clk);
    rst = 1'b0; strt_cal = 1'b0; vld = 1'b0;
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom_range(0, 65535));
  endfunction

  task automatic calibrate_const(input logic [15:0] p, input logic [15:0] r, input logic [15:0] y,
                                 input string tag);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, {tag, "_start"});
    for (int i = 0; i < N; i++) cyc(0, 0, 1, p, r, y, 0, 0, tag);
  endtask

  task automatic run_random(input int n, input string tag);
    for (int i = 0; i < n; i++)
      cyc(0, 0, ($urandom_range(0, 3) != 0), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), tag);
  endtask

  initial begin
    rst = 1'b1; strt_cal = 1'b0; vld = 1'b0;
    ptch_rt = '0; roll_rt = '0; yaw_rt = '0; ax = '0; ay = '0;
    m_mode = 0; m_done = 0;
    for (int i = 0; i < 3; i++) m_off[i] = 0;
    model_clear();

    // reset, then vld in IDLE is ignored
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, "reset");
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), "idle_vld");

    // calibration with constant rates, cal_done exactly on the 256th sample
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "cal_start");
    for (int i = 0; i < N - 1; i++) cyc(0, 0, 1, 16'd16, -16'sd5, 16'd3, 0, 0, "cal");
    check("cal_done_before_last", {15'd0, cal_done}, 16'd0);
    cyc(0, 0, 1, 16'd16, -16'sd5, 16'd3, 0, 0, "cal_last");
    check("cal_done_on_last", {15'd0, cal_done}, 16'd1);
    for (int i = 0; i < 64; i++) cyc(0, 0, 1, 16'd16, -16'sd5, 16'd3, 0, 0, "run_const");
    check("yaw_zero_at_offset", yaw, 16'd0);

    // yaw integration: 64 samples of +2048 above offset
    calibrate_const(16'd16, -16'sd5, 16'd3, "recal_yaw");
    for (int i = 0; i < 64; i++) cyc(0, 0, 1, 16'd16, -16'sd5, 16'd3 + 16'd2048, 0, 0, "yaw_int");
    check("yaw_integrated", yaw, 16'd64);

    // pitch fusion: rate at offset, ay=1000 pulls pitch up by FUSION per sample
    calibrate_const(16'd16, -16'sd5, 16'd3, "recal_fus");
    cyc(0, 0, 1, 16'd16, -16'sd5, 16'd3, 0, 16'd1000, "fus1");
    cyc(0, 0, 1, 16'd16, -16'sd5, 16'd3, 0, 16'd1000, "fus2");
    check("ptch_fused", ptch, 16'd1);

    // calibration restart after 100 samples; offsets from the last 256 only
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "restart_a");
    for (int i = 0; i < 100; i++) cyc(0, 0, 1, rnd16(), rnd16(), rnd16(), 0, 0, "cal_partial");
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "restart_b");
    for (int i = 0; i < N - 1; i++)
      cyc(0, 0, 1, 16'($signed(16'($urandom_range(0, 2000))) - 16'sd1000), rnd16(), rnd16(), 0, 0,
          "cal_rand");
    check("restart_not_done", {15'd0, cal_done}, 16'd0);
    cyc(0, 0, 1, rnd16(), rnd16(), rnd16(), 0, 0, "cal_rand_last");
    check("restart_done", {15'd0, cal_done}, 16'd1);
    run_random(200, "run_rand");

    // reset in RUN: full clear, vld ignored until strt_cal
    cyc(1, 0, 1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), "rst_run");
    check("rst_run_cal_done", {15'd0, cal_done}, 16'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), "post_rst_vld");

    // strt_cal coincident with vld in RUN: sample dropped, count restarts
    cyc(0, 1, 0, 0, 0, 0, 0, 0, "cal3_start");
    for (int i = 0; i < N; i++) cyc(0, 0, 1, rnd16(), rnd16(), rnd16(), 0, 0, "cal3");
    run_random(30, "run3");
    cyc(0, 1, 1, rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), "strt_with_vld");
    check("strt_with_vld_ptch", ptch, 16'd0);
    for (int i = 0; i < N - 1; i++) cyc(0, 0, 1, rnd16(), rnd16(), rnd16(), 0, 0, "cal4");
    check("cal4_not_done", {15'd0, cal_done}, 16'd0);
    cyc(0, 0, 1, rnd16(), rnd16(), rnd16(), 0, 0, "cal4_last");
    check("cal4_done", {15'd0, cal_done}, 16'd1);
    run_random(50, "run4");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
